// File: rtl/pio_ctrl_regs.sv
// PIO register slave for the SAP1 control block.
// ID/scratch, run/step/halt control, cycle counter and program-memory window.
module pio_ctrl_regs #(
    parameter logic [31:0] ID_VALUE  = 32'h5A50_0001,
    parameter logic [31:0] BAD_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pio_addr,
    input  logic [31:0] pio_data_w,
    input  logic        pio_rw,
    input  logic        pio_cmd_vld,
    output logic        pio_rd_vld,
    output logic [31:0] pio_data_r,
    input  logic        core_hlt,
    output logic        core_run,
    output logic        core_clr,
    output logic        pmem_we,
    output logic [3:0]  pmem_addr,
    output logic [7:0]  pmem_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [15:0] ADDR_ID      = 16'h0000;
    localparam logic [15:0] ADDR_CTRL    = 16'h0004;
    localparam logic [15:0] ADDR_STATUS  = 16'h0008;
    localparam logic [15:0] ADDR_CYCLES  = 16'h000C;
    localparam logic [15:0] ADDR_SCRATCH = 16'h0010;
    localparam logic [9:0]  PMEM_PAGE    = 10'h004;

    state_t      state;
    state_t      state_next;
    logic        core_run_next;
    logic        core_clr_next;

    logic [31:0] cycles;
    logic [31:0] scratch;
    logic        pmem_err;
    logic [7:0]  pmem_shadow [16];

    logic        aligned;
    logic        hit_id;
    logic        hit_ctrl;
    logic        hit_status;
    logic        hit_cycles;
    logic        hit_scratch;
    logic        hit_pmem;
    logic        rd;
    logic        wr;
    logic        ctrl_wr;
    logic        cmd_clear;
    logic        cmd_halt;
    logic        cmd_step;
    logic        cmd_run;
    logic        pmem_open;
    logic        pmem_ok;
    logic        pmem_bad;
    logic [31:0] status_word;
    logic [31:0] rdata_next;

    // Address decode and command qualification for the current bus cycle.
    always_comb begin
        aligned     = (pio_addr[1:0] == 2'b00);
        hit_id      = (pio_addr == ADDR_ID);
        hit_ctrl    = (pio_addr == ADDR_CTRL);
        hit_status  = (pio_addr == ADDR_STATUS);
        hit_cycles  = (pio_addr == ADDR_CYCLES);
        hit_scratch = (pio_addr == ADDR_SCRATCH);
        hit_pmem    = aligned && (pio_addr[15:6] == PMEM_PAGE);
        rd          = pio_cmd_vld && pio_rw;
        wr          = pio_cmd_vld && !pio_rw;
        ctrl_wr     = wr && hit_ctrl;
        cmd_clear   = ctrl_wr && pio_data_w[3];
        cmd_halt    = ctrl_wr && pio_data_w[2];
        cmd_step    = ctrl_wr && pio_data_w[1];
        cmd_run     = ctrl_wr && pio_data_w[0];
        pmem_open   = (state == ST_IDLE) || (state == ST_HALT);
        pmem_ok     = wr && hit_pmem && pmem_open;
        pmem_bad    = wr && hit_pmem && !pmem_open;
    end

    // Control FSM next state; clear beats everything, halt beats step/run.
    always_comb begin
        state_next    = state;
        core_clr_next = cmd_clear;
        if (cmd_clear) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (cmd_halt || core_hlt) begin
                        state_next = ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_next = ST_HALT;
                end
                ST_IDLE, ST_HALT: begin
                    if (cmd_halt) begin
                        state_next = state;
                    end else if (cmd_step) begin
                        state_next = ST_STEP;
                    end else if (cmd_run) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
        core_run_next = (state_next == ST_RUN) || (state_next == ST_STEP);
    end

    // FSM state and registered core controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            core_run <= 1'b0;
            core_clr <= 1'b0;
        end else begin
            state    <= state_next;
            core_run <= core_run_next;
            core_clr <= core_clr_next;
        end
    end

    // Saturating run-cycle counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= 32'd0;
        end else if (cmd_clear) begin
            cycles <= 32'd0;
        end else if (core_run && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end

    // Scratch register.
    always_ff @(posedge clk) begin
        if (reset) begin
            scratch <= 32'd0;
        end else if (wr && hit_scratch) begin
            scratch <= pio_data_w;
        end
    end

    // Sticky flag for program-memory writes attempted while the core runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pmem_err <= 1'b0;
        end else if (cmd_clear) begin
            pmem_err <= 1'b0;
        end else if (pmem_bad) begin
            pmem_err <= 1'b1;
        end
    end

    // Program-memory write port and its readable shadow copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            pmem_we    <= 1'b0;
            pmem_addr  <= 4'd0;
            pmem_wdata <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                pmem_shadow[i] <= 8'd0;
            end
        end else begin
            pmem_we <= pmem_ok;
            if (pmem_ok) begin
                pmem_addr                   <= pio_addr[5:2];
                pmem_wdata                  <= pio_data_w[7:0];
                pmem_shadow[pio_addr[5:2]]  <= pio_data_w[7:0];
            end
        end
    end

    // Read data mux; core_hlt is reported live.
    always_comb begin
        status_word       = 32'd0;
        status_word[1:0]  = state;
        status_word[8]    = core_hlt;
        status_word[9]    = pmem_err;
        rdata_next        = BAD_RDATA;
        if (hit_id) begin
            rdata_next = ID_VALUE;
        end else if (hit_ctrl) begin
            rdata_next = 32'd0;
        end else if (hit_status) begin
            rdata_next = status_word;
        end else if (hit_cycles) begin
            rdata_next = cycles;
        end else if (hit_scratch) begin
            rdata_next = scratch;
        end else if (hit_pmem) begin
            rdata_next = {24'd0, pmem_shadow[pio_addr[5:2]]};
        end
    end

    // One-cycle read response; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            pio_rd_vld <= 1'b0;
            pio_data_r <= 32'd0;
        end else begin
            pio_rd_vld <= rd;
            if (rd) begin
                pio_data_r <= rdata_next;
            end
        end
    end

endmodule
